// File: rtl/cook_pkg.sv
// cook_pkg
//   Shared definitions for the cook timer S/R latch driver.
//   - cook_state_t : FSM state encoding (IDLE, SET_P, COOK, RST_P)
//   - DEFAULT_CLK_PER_SEC / DEFAULT_PULSE_CYCLES : default parameter values
package cook_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        COOK  = 2'd2,
        RST_P = 2'd3
    } cook_state_t;

    localparam int DEFAULT_CLK_PER_SEC  = 50_000_000;
    localparam int DEFAULT_PULSE_CYCLES = 4;

endpackage

// File: rtl/sr_debounce.sv
// sr_debounce
//   1-bit input conditioner: two-flop synchronizer followed by a stability
//   filter. The output only follows the input after it has held the same
//   value for DB_CYCLES consecutive cycles.
//   Parameters: DB_CYCLES  stability window in cycles (>=1)
//               RESET_VAL  value presented on the output while in reset
//   Ports:      clk, rst_n (async active-low), din (raw), dout (filtered)
module sr_debounce #(
    parameter int   DB_CYCLES = 16,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          din_meta;
    logic          din_sync;
    logic [CW-1:0] stable_cnt;

    // Synchronize the raw input, then count how long it has differed from
    // the current output; commit the new level once the window is filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_meta   <= RESET_VAL;
            din_sync   <= RESET_VAL;
            dout       <= RESET_VAL;
            stable_cnt <= '0;
        end else begin
            din_meta <= din;
            din_sync <= din_meta;
            if (din_sync == dout) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DB_CYCLES - 1)) begin
                dout       <= din_sync;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cook_sr_driver.sv
// cook_sr_driver
//   Cook timer that drives a downstream SR latch controlling the magnetron.
//   An accepted start issues an S pulse, counts down time_sec seconds, then
//   issues an R pulse. Cancel or an open door aborts the cook with an R pulse.
//
//   Parameters: CLK_PER_SEC  clock cycles per timer second (>=2)
//               PULSE_CYCLES width of each S/R pulse (1..15)
//               DB_CYCLES    debounce window (only with COOK_SR_DEBOUNCE_EN)
//   Ports:      clk, rst_n      clock, async active-low reset
//               start_btn       start request (rising edge starts)
//               cancel_btn      cancel request (level)
//               door_open       door sensor, 1 = open
//               time_sec[7:0]   cook time, sampled on accepted start
//               S, R            set / reset commands to the SR latch
//               busy            high in SET_P, COOK, RST_P
//               done            one-cycle pulse on timeout completion
//               remaining[7:0]  seconds left, 0 when idle
//   Configuration: define COOK_SR_DEBOUNCE_EN to debounce the three button
//   and sensor inputs; otherwise they only pass a two-flop synchronizer.
module cook_sr_driver
    import cook_pkg::*;
#(
    parameter int CLK_PER_SEC  = DEFAULT_CLK_PER_SEC,
    parameter int PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
    parameter int DB_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       cancel_btn,
    input  logic       door_open,
    input  logic [7:0] time_sec,
    output logic       S,
    output logic       R,
    output logic       busy,
    output logic       done,
    output logic [7:0] remaining
);

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    logic start_s;
    logic cancel_s;
    logic door_s;

`ifdef COOK_SR_DEBOUNCE_EN
    // Start and door reset to 1 so a held button or unknown door cannot
    // look like a fresh, safe start right after reset.
    sr_debounce #(.DB_CYCLES(DB_CYCLES), .RESET_VAL(1'b1)) u_db_start (
        .clk(clk), .rst_n(rst_n), .din(start_btn), .dout(start_s)
    );
    sr_debounce #(.DB_CYCLES(DB_CYCLES), .RESET_VAL(1'b0)) u_db_cancel (
        .clk(clk), .rst_n(rst_n), .din(cancel_btn), .dout(cancel_s)
    );
    sr_debounce #(.DB_CYCLES(DB_CYCLES), .RESET_VAL(1'b1)) u_db_door (
        .clk(clk), .rst_n(rst_n), .din(door_open), .dout(door_s)
    );
`else
    logic start_meta;
    logic cancel_meta;
    logic door_meta;

    // Plain two-flop synchronizers; start and door reset high for the same
    // reason as the debounced build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_meta  <= 1'b1;
            start_s     <= 1'b1;
            cancel_meta <= 1'b0;
            cancel_s    <= 1'b0;
            door_meta   <= 1'b1;
            door_s      <= 1'b1;
        end else begin
            start_meta  <= start_btn;
            start_s     <= start_meta;
            cancel_meta <= cancel_btn;
            cancel_s    <= cancel_meta;
            door_meta   <= door_open;
            door_s      <= door_meta;
        end
    end
`endif

    cook_state_t   state;
    cook_state_t   state_n;
    logic          start_prev;
    logic          start_edge;
    logic          abort;
    logic [3:0]    pulse_cnt;
    logic [3:0]    pulse_cnt_n;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;
    logic [7:0]    remaining_n;
    logic          done_n;

    assign start_edge = start_s & ~start_prev;
    assign abort      = cancel_s | door_s;

    // Edge-detector history resets to 1 so a button held through reset
    // never produces a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev <= 1'b1;
        end else begin
            start_prev <= start_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counters and the registered done pulse; done lands in the first
    // RST_P cycle together with remaining = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt <= '0;
            presc     <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            pulse_cnt <= pulse_cnt_n;
            presc     <= presc_n;
            remaining <= remaining_n;
            done      <= done_n;
        end
    end

    // Next-state and counter logic. Abort is checked before the timeout
    // decrement so a cancel in the same cycle suppresses done.
    always_comb begin
        state_n     = state;
        pulse_cnt_n = pulse_cnt;
        presc_n     = presc;
        remaining_n = remaining;
        done_n      = 1'b0;
        unique case (state)
            IDLE: begin
                remaining_n = '0;
                if (start_edge && !abort && (time_sec != 8'd0)) begin
                    state_n     = SET_P;
                    remaining_n = time_sec;
                    presc_n     = '0;
                    pulse_cnt_n = '0;
                end
            end
            SET_P: begin
                if (abort) begin
                    state_n     = RST_P;
                    remaining_n = '0;
                    pulse_cnt_n = '0;
                end else if (pulse_cnt == 4'(PULSE_CYCLES - 1)) begin
                    state_n     = COOK;
                    pulse_cnt_n = '0;
                    presc_n     = '0;
                end else begin
                    pulse_cnt_n = pulse_cnt + 4'd1;
                end
            end
            COOK: begin
                if (abort) begin
                    state_n     = RST_P;
                    remaining_n = '0;
                    pulse_cnt_n = '0;
                end else if (presc == PW'(CLK_PER_SEC - 1)) begin
                    presc_n = '0;
                    if (remaining <= 8'd1) begin
                        state_n     = RST_P;
                        remaining_n = '0;
                        pulse_cnt_n = '0;
                        done_n      = 1'b1;
                    end else begin
                        remaining_n = remaining - 8'd1;
                    end
                end else begin
                    presc_n = presc + PW'(1);
                end
            end
            RST_P: begin
                if (pulse_cnt == 4'(PULSE_CYCLES - 1)) begin
                    state_n     = IDLE;
                    pulse_cnt_n = '0;
                end else begin
                    pulse_cnt_n = pulse_cnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs decode directly from state so reset clears them immediately.
    assign S    = (state == SET_P);
    assign R    = (state == RST_P);
    assign busy = (state != IDLE);

endmodule
